// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall/flush generation, precise
// MEM-stage exception sequencing with redirect PC, and stall/flush event counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0] ERET_CODE = 32'h0000000e;

    typedef enum logic [1:0] {IDLE, WAIT_BUS, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [31:0] exc_q, epc_q;
    logic        capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            exc_q <= 32'h0;
            epc_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                exc_q <= excepttype_i;
                epc_q <= cp0_epc_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'h0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (excepttype_i != 32'h0) begin
                    // Hold everything up to MEM so WB takes a bubble, not the faulting instr
                    stall     = 6'b011111;
                    capture   = 1'b1;
                    state_nxt = stallreq_from_mem ? WAIT_BUS : FLUSH;
                end else if (stallreq_from_mem) begin
                    stall = 6'b011111;
                end else if (stallreq_from_ex) begin
                    stall = 6'b001111;
                end else if (stallreq_from_id || stallreq_from_if) begin
                    stall = 6'b000111;
                end
            end
            WAIT_BUS: begin
                // Flushing mid-transaction would corrupt the bus; wait it out
                stall = 6'b011111;
                if (!stallreq_from_mem)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                flush     = 1'b1;
                new_pc    = (exc_q == ERET_CODE) ? epc_q : EXC_VECTOR;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stall  = 6'b000000;
            flush  = 1'b0;
            new_pc = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall[0])
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (state == FLUSH)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expected outputs are queued when
// stimulus is driven and compared at the following negative clock edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_if, s_id, s_ex, s_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    int exp_scnt = 0;
    int exp_fcnt = 0;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    pipe_ctrl #(.EXC_VECTOR(32'h00000020), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(s_if), .stallreq_from_id(s_id),
        .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".stall"}, 64'(stall),  64'(e.stall));
            chk({e.tag, ".flush"}, 64'(flush),  64'(e.flush));
            chk({e.tag, ".pc"},    64'(new_pc), 64'(e.pc));
        end
    end

    // Drive one cycle of inputs (just after a posedge), queue the expected
    // combinational outputs for this cycle, then advance past the next edge.
    task automatic step(input string tag, input logic i_if, input logic i_id,
                        input logic i_ex, input logic i_mem,
                        input logic [31:0] i_exc, input logic [31:0] i_epc,
                        input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc);
        exp_t e;
        s_if = i_if; s_id = i_id; s_ex = i_ex; s_mem = i_mem;
        exc = i_exc; epc = i_epc;
        e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.pc = e_pc;
        sb.push_back(e);
        if (e_stall[0]) exp_scnt++;
        if (e_flush)    exp_fcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_scnt));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(exp_fcnt));
    endtask

    initial begin
        // Reset with hostile inputs: outputs must still be forced low
        rst = 1'b1;
        s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1; s_mem = 1'b1;
        exc = 32'h8; epc = 32'hdead_beef;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.stall", 64'(stall), 64'(6'b0));
        chk("rst.flush", 64'(flush), 64'(1'b0));
        chk("rst.pc",    64'(new_pc), 64'h0);
        chk_cnt("rst");
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; exc = 0; epc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stall priority
        repeat (3) step("id_ex", 0, 1, 1, 0, 0, 0, 6'b001111, 0, 0);
        chk_cnt("id_ex");
        step("idle0",  0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        step("if",     1, 0, 0, 0, 0, 0, 6'b000111, 0, 0);
        step("id",     0, 1, 0, 0, 0, 0, 6'b000111, 0, 0);
        step("mem_all",1, 1, 1, 1, 0, 0, 6'b011111, 0, 0);
        step("ex_if",  1, 0, 1, 0, 0, 0, 6'b001111, 0, 0);
        chk_cnt("prio");

        // Syscall, bus idle
        step("sys.det", 0, 0, 0, 0, 32'h8, 0, 6'b011111, 0, 0);
        step("sys.fl",  0, 0, 0, 0, 0,     0, 6'b000000, 1, 32'h20);
        step("sys.idl", 0, 0, 0, 0, 0,     0, 6'b000000, 0, 0);
        chk_cnt("sys");

        // ERET with EPC changing after detect
        step("eret.det", 0, 0, 0, 0, 32'he, 32'h1234, 6'b011111, 0, 0);
        step("eret.fl",  0, 0, 0, 0, 0,     32'h5555, 6'b000000, 1, 32'h1234);
        step("eret.idl", 0, 0, 0, 0, 0,     32'h5555, 6'b000000, 0, 0);

        // Overflow during bus busy
        step("bus.det", 0, 0, 0, 1, 32'hc, 32'h40, 6'b011111, 0, 0);
        repeat (4) step("bus.wait", 0, 1, 1, 1, 0, 32'h40, 6'b011111, 0, 0);
        step("bus.drop", 0, 0, 0, 0, 0, 32'h40, 6'b011111, 0, 0);
        step("bus.fl",   0, 0, 0, 0, 0, 32'h40, 6'b000000, 1, 32'h20);
        step("bus.idl",  0, 0, 0, 0, 0, 32'h40, 6'b000000, 0, 0);
        chk_cnt("bus");

        // Exception held through WAIT_BUS and FLUSH issues only one flush
        step("mask.det", 0, 0, 0, 1, 32'h1, 32'h80, 6'b011111, 0, 0);
        step("mask.wt",  0, 1, 0, 0, 32'h1, 32'h80, 6'b011111, 0, 0);
        step("mask.fl",  0, 0, 1, 0, 32'he, 32'h80, 6'b000000, 1, 32'h20);
        step("mask.idl", 0, 0, 0, 0, 32'h0, 32'h80, 6'b000000, 0, 0);
        chk_cnt("mask");

        // Trap code, back-to-back with minimum spacing
        step("trap.det", 0, 0, 0, 0, 32'hd, 0, 6'b011111, 0, 0);
        step("trap.fl",  0, 0, 0, 0, 32'hd, 0, 6'b000000, 1, 32'h20);
        step("trap2.det",0, 0, 0, 0, 32'he, 32'h9abc, 6'b011111, 0, 0);
        step("trap2.fl", 0, 0, 0, 0, 0,     0, 6'b000000, 1, 32'h9abc);
        chk_cnt("trap");

        // Async reset mid-WAIT_BUS
        step("rwb.det", 0, 0, 0, 1, 32'h8, 0, 6'b011111, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rwb.stall", 64'(stall),  64'(6'b0));
        chk("rwb.flush", 64'(flush),  64'(1'b0));
        chk("rwb.pc",    64'(new_pc), 64'h0);
        exp_scnt = 0;
        exp_fcnt = 0;
        chk_cnt("rwb");
        s_mem = 1'b0; exc = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("rwb.a", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        step("rwb.b", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        chk_cnt("rwb.post");

        @(negedge clk);
        chk("sb.empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
